// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: program counter, instruction-memory address, IF/ID register.
// Optional perf counters (fetch_cnt_o, stall_cnt_o) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        misalign_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
`endif
  output logic        state_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic        misalign_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
`endif

  logic [31:0] pc_inc_d;
  logic [31:0] redirect_tgt_d;
  logic        misalign_d;

  // Redirect targets are force-aligned; the dropped low bits only raise misalign.
  assign pc_inc_d       = pc_q + 32'd4;
  assign redirect_tgt_d = {redirect_pc_i[31:2], 2'b00};
  assign misalign_d     = redirect_i && (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      instr_q     <= 32'h0;
      ifid_pc_q   <= 32'h0;
      ifid_pc4_q  <= 32'h0;
      misalign_q  <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
`endif
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          misalign_q <= 1'b0;
        end
        RUN: begin
          misalign_q <= misalign_d;
          if (redirect_i) begin
            // Whatever is on instr_i this cycle is wrong-path.
            pc_q    <= redirect_tgt_d;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
          end else if (stall_i) begin
`ifdef FETCH_PERF_CNT_EN
            stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
            if (flush_i) begin
              valid_q <= 1'b0;
              instr_q <= 32'h0;
            end
          end else begin
            pc_q <= pc_inc_d;
            if (flush_i) begin
              valid_q <= 1'b0;
              instr_q <= 32'h0;
            end else begin
              valid_q    <= 1'b1;
              instr_q    <= instr_i;
              ifid_pc_q  <= pc_q;
              ifid_pc4_q <= pc_inc_d;
`ifdef FETCH_PERF_CNT_EN
              fetch_cnt_q <= fetch_cnt_q + 32'd1;
`endif
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc_addr_o    = pc_q;
  assign ifid_valid_o = valid_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign misalign_o   = misalign_q;
  assign state_o      = state_q;
`ifdef FETCH_PERF_CNT_EN
  assign fetch_cnt_o  = fetch_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: two instances (RESET_PC 0 and 32'hFFFF_FFFC) on shared inputs,
// a rule-level reference model compared every cycle, plus hand-computed literal checks.
module tb_instr_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;

  logic [31:0] pc_o    [2];
  logic [31:0] instr_i [2];
  logic        valid_o [2];
  logic [31:0] instr_o [2];
  logic [31:0] ifpc_o  [2];
  logic [31:0] ifpc4_o [2];
  logic        mis_o   [2];
  logic        st_o    [2];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_o  [2];
  logic [31:0] scnt_o  [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem(logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h0000_0013;
  endfunction

  assign instr_i[0] = imem(pc_o[0]);
  assign instr_i[1] = imem(pc_o[1]);

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pc_addr_o(pc_o[0]), .instr_i(instr_i[0]), .ifid_valid_o(valid_o[0]),
    .ifid_instr_o(instr_o[0]), .ifid_pc_o(ifpc_o[0]), .ifid_pc4_o(ifpc4_o[0]),
    .misalign_o(mis_o[0]),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fcnt_o[0]), .stall_cnt_o(scnt_o[0]),
`endif
    .state_o(st_o[0])
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pc_addr_o(pc_o[1]), .instr_i(instr_i[1]), .ifid_valid_o(valid_o[1]),
    .ifid_instr_o(instr_o[1]), .ifid_pc_o(ifpc_o[1]), .ifid_pc4_o(ifpc4_o[1]),
    .misalign_o(mis_o[1]),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fcnt_o[1]), .stall_cnt_o(scnt_o[1]),
`endif
    .state_o(st_o[1])
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        run;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic        mis;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, logic [31:0] reset_pc, logic rst, logic stall,
                                logic flush, logic redir, logic [31:0] rpc);
    mdl_t r = m;
    bit   loads;
    if (rst) begin
      r    = '0;
      r.pc = reset_pc;
    end else if (!m.run) begin
      r.run = 1'b1;
      r.mis = 1'b0;
    end else begin
      r.mis = redir && (rpc % 4 != 0);
      if (redir)      r.pc = rpc - (rpc % 4);
      else if (!stall) r.pc = m.pc + 4;
      loads = !redir && !stall && !flush;
      if (loads) begin
        r.valid = 1'b1;
        r.instr = imem(m.pc);
        r.ifpc  = m.pc;
        r.ifpc4 = m.pc + 4;
        r.fcnt  = m.fcnt + 1;
      end else if (redir || flush) begin
        r.valid = 1'b0;
        r.instr = 32'h0;
      end
      if (stall && !redir) r.scnt = m.scnt + 1;
    end
    return r;
  endfunction

  always @(posedge clk_i) begin
    m0 <= step(m0, 32'h0000_0000, rst_i, stall_i, flush_i, redirect_i, redirect_pc_i);
    m1 <= step(m1, 32'hFFFF_FFFC, rst_i, stall_i, flush_i, redirect_i, redirect_pc_i);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp(int i, mdl_t m);
    string s = $sformatf("[%0d]@%0t", i, $time);
    chk({"pc", s}, pc_o[i], m.pc);
    chk({"valid", s}, {31'b0, valid_o[i]}, {31'b0, m.valid});
    chk({"instr", s}, instr_o[i], m.instr);
    chk({"misalign", s}, {31'b0, mis_o[i]}, {31'b0, m.mis});
    chk({"state", s}, {31'b0, st_o[i]}, {31'b0, m.run});
    if (m.valid) begin
      chk({"ifid_pc", s}, ifpc_o[i], m.ifpc);
      chk({"ifid_pc4", s}, ifpc4_o[i], m.ifpc4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk({"fetch_cnt", s}, fcnt_o[i], m.fcnt);
    chk({"stall_cnt", s}, scnt_o[i], m.scnt);
`endif
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      cmp(0, m0);
      cmp(1, m1);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(logic rst, logic stall, logic flush, logic redir, logic [31:0] rpc);
    rst_i         = rst;
    stall_i       = stall;
    flush_i       = flush;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // reset / boot
    drive(1, 0, 0, 0, 32'h0);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 32'h0);
    chk("rst_pc0", pc_o[0], 32'h0);
    chk("rst_valid0", {31'b0, valid_o[0]}, 32'h0);
    chk("rst_instr0", instr_o[0], 32'h0);
    chk("rst_ifpc0", ifpc_o[0], 32'h0);
    chk("rst_ifpc4_0", ifpc4_o[0], 32'h0);
    chk("rst_mis0", {31'b0, mis_o[0]}, 32'h0);
    chk("rst_state0", {31'b0, st_o[0]}, 32'h0);
    chk("rst_pc1", pc_o[1], 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 32'h0);
    chk("boot_pc0", pc_o[0], 32'h0);
    chk("boot_valid0", {31'b0, valid_o[0]}, 32'h0);
    chk("boot_state0", {31'b0, st_o[0]}, 32'h1);
    drive(0, 0, 0, 0, 32'h0);
    chk("cap_pc0", pc_o[0], 32'h4);
    chk("cap_valid0", {31'b0, valid_o[0]}, 32'h1);
    chk("cap_ifpc0", ifpc_o[0], 32'h0);
    chk("cap_ifpc4_0", ifpc4_o[0], 32'h4);
    chk("cap_instr0", instr_o[0], 32'h13);
    chk("wrap_pc1", pc_o[1], 32'h0);
    chk("wrap_ifpc1", ifpc_o[1], 32'hFFFF_FFFC);
    chk("wrap_ifpc4_1", ifpc4_o[1], 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    chk("run_pc0", pc_o[0], 32'h8);
    // stall three cycles at PC=8
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 32'h0);
      chk("stall_pc0", pc_o[0], 32'h8);
      chk("stall_ifpc0", ifpc_o[0], 32'h4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt0", scnt_o[0], 32'd3);
`endif
    drive(0, 0, 0, 0, 32'h0);
    chk("resume_pc0", pc_o[0], 32'hC);
    // redirect overrides stall
    drive(0, 1, 0, 1, 32'h40);
    chk("rs_pc0", pc_o[0], 32'h40);
    chk("rs_valid0", {31'b0, valid_o[0]}, 32'h0);
    chk("rs_instr0", instr_o[0], 32'h0);
    chk("rs_mis0", {31'b0, mis_o[0]}, 32'h0);
    // misaligned redirect
    drive(0, 0, 0, 1, 32'h23);
    chk("mis_pc0", pc_o[0], 32'h20);
    chk("mis_flag0", {31'b0, mis_o[0]}, 32'h1);
    drive(0, 0, 0, 0, 32'h0);
    chk("mis_clear0", {31'b0, mis_o[0]}, 32'h0);
    chk("tgt_valid0", {31'b0, valid_o[0]}, 32'h1);
    chk("tgt_ifpc0", ifpc_o[0], 32'h20);
    // flush with stall
    drive(0, 1, 1, 0, 32'h0);
    chk("fs_pc0", pc_o[0], 32'h24);
    chk("fs_valid0", {31'b0, valid_o[0]}, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    chk("fs_resume_pc0", pc_o[0], 32'h28);
    // reach PC=0x18 with IF/ID valid, then reset mid-run
    drive(0, 0, 0, 1, 32'h10);
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    chk("pre_rst_pc0", pc_o[0], 32'h18);
    chk("pre_rst_valid0", {31'b0, valid_o[0]}, 32'h1);
    drive(1, 0, 0, 0, 32'h0);
    chk("mr_pc0", pc_o[0], 32'h0);
    chk("mr_valid0", {31'b0, valid_o[0]}, 32'h0);
    chk("mr_state0", {31'b0, st_o[0]}, 32'h0);
    chk("mr_pc1", pc_o[1], 32'hFFFF_FFFC);
    // BOOT ignores control inputs
    drive(0, 1, 1, 1, 32'h81);
    chk("p2_pc1", pc_o[1], 32'hFFFF_FFFC);
    chk("p2_state1", {31'b0, st_o[1]}, 32'h1);
    chk("p2_mis1", {31'b0, mis_o[1]}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("p2_scnt1", scnt_o[1], 32'h0);
`endif
    // flush on the capture edge across the wrap
    drive(0, 0, 1, 0, 32'h0);
    chk("fl_pc1", pc_o[1], 32'h0);
    chk("fl_valid1", {31'b0, valid_o[1]}, 32'h0);
    chk("fl_instr1", instr_o[1], 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    chk("fl2_pc1", pc_o[1], 32'h4);
    chk("fl2_valid1", {31'b0, valid_o[1]}, 32'h1);
    chk("fl2_ifpc1", ifpc_o[1], 32'h0);
    chk("fl2_ifpc4_1", ifpc4_o[1], 32'h4);
`ifdef FETCH_PERF_CNT_EN
    chk("fl2_fcnt1", fcnt_o[1], 32'h1);
`endif
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage for the single-cycle/pipelined CPU datapath. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into an IF/ID pipeline register. Downstream, the decoder and register file consume this register. The stage handles stall, flush, and control-flow redirect requests from later stages.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  sole clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- stall_i  input  1  hold PC and IF/ID contents.
- flush_i  input  1  kill the instruction being captured into IF/ID.
- redirect_i  input  1  load redirect_pc_i into PC (branch/jump taken).
- redirect_pc_i  input  32  redirect target byte address.
- pc_addr_o  output  32  current PC, goes to instruction memory address input (combinational read).
- instr_i  input  32  instruction word returned by memory for pc_addr_o, same cycle.
- ifid_valid_o  output  1  IF/ID holds a live instruction.
- ifid_instr_o  output  32  captured instruction.
- ifid_pc_o  output  32  PC of captured instruction.
- ifid_pc4_o  output  32  ifid_pc_o + 4.
- misalign_o  output  1  one-cycle pulse: last redirect target had nonzero bits [1:0].
- fetch_cnt_o  output  32  present only with the configuration macro (see Configuration).
- stall_cnt_o  output  32  present only with the configuration macro (see Configuration).

## Operation
- FSM states:
  - BOOT (reset state): the PC holds RESET_PC and IF/ID is not loaded with valid data.
  - RUN.
- FSM transitions:
  - BOOT → RUN on the first clock after rst_i deasserts, unconditionally.
  - RUN → BOOT only on rst_i.
- Per-edge priority in RUN is rst_i > redirect_i > stall_i > normal.
  - Normal: PC ← PC+4; IF/ID ← {valid=1, instr_i, PC, PC+4}.
  - stall_i: PC and IF/ID unchanged.
  - redirect_i: PC ← {redirect_pc_i[31:2], 2'b00}; IF/ID valid ← 0 (the instruction fetched this cycle is wrong-path). Redirect overrides stall.
  - flush_i: IF/ID valid ← 0. PC follows the rules above, so flush with stall clears valid and holds the PC.
- misalign_o is 1 in the cycle after a redirect whose redirect_pc_i[1:0] ≠ 0, and 0 otherwise. The target is always force-aligned.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag. ifid_pc4_o wraps identically.
- When IF/ID valid is 0, ifid_instr_o is 32'h0 (NOP). ifid_pc_o and ifid_pc4_o keep their last written values.
- In BOOT, stall_i, flush_i and redirect_i are ignored.

## Timing
- Reset values:
  - pc_addr_o = RESET_PC.
  - ifid_valid_o = 0, ifid_instr_o = 0, ifid_pc_o = 0, ifid_pc4_o = 0.
  - misalign_o = 0.
  - Counters = 0.
  - State = BOOT.
- Reset asserted mid-operation takes effect at the next edge and overrides all other inputs.
- Address-to-IF/ID latency is one cycle: the instruction at pc_addr_o in cycle n appears on ifid_* in cycle n+1.
- After rst_i falls, the first valid IF/ID appears 2 edges later: the BOOT edge, then the capture edge.
- A redirect in cycle n gives pc_addr_o = target in cycle n+1 and ifid_valid_o = 0 in cycle n+1. The target instruction is valid in cycle n+2.
- All outputs are registered except pc_addr_o, which is the PC register output directly.

## Configuration
- Macro name: FETCH_PERF_CNT_EN.
- When defined:
  - fetch_cnt_o increments on every edge in RUN that loads IF/ID with valid=1.
  - stall_cnt_o increments on every edge in RUN with stall_i=1 and redirect_i=0.
  - Both are 32-bit wrapping counters, cleared by rst_i.
- When undefined: both ports and their registers are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset/boot: rst_i=1 for 2 cycles with RESET_PC=0, then release. Required:
  - pc_addr_o = 0, 0, 4, 8, … on successive cycles.
  - ifid_valid_o first 1 two edges after release, with ifid_pc_o=0 and ifid_pc4_o=4.
- Stall: stall_i=1 for 3 cycles at PC=8. Required:
  - pc_addr_o stays 8 and IF/ID holds PC=4.
  - Resume gives PC=12.
  - stall_cnt_o = 3 when the macro is defined.
- Redirect plus stall: redirect_i=1, redirect_pc_i=32'h40, stall_i=1 at PC=12. Required next cycle: pc_addr_o=32'h40, ifid_valid_o=0, ifid_instr_o=0, misalign_o=0.
- Misaligned redirect: redirect_pc_i=32'h23. Required next cycle: pc_addr_o=32'h20 and misalign_o=1 for exactly one cycle.
- Wrap and flush: RESET_PC=32'hFFFF_FFFC. Required:
  - After boot, pc_addr_o goes 32'hFFFF_FFFC → 0.
  - Flush on the capture edge gives ifid_valid_o=0 while the PC still advances to 4.
- Reset mid-run: rst_i=1 for one cycle at PC=32'h18 with IF/ID valid. Required next cycle: pc_addr_o=RESET_PC, ifid_valid_o=0, state BOOT.
